// File: rtl/tx_axi_riffa_if.sv
// RIFFA RX channel and AXI4-Stream bundles used by tx_axi_riffa.
// Signal names follow the RIFFA/AXIS naming the host-side and generator-side logic already use.
interface riffa_rx_if;
  logic         CHNL_RX;
  logic         CHNL_RX_ACK;
  logic         CHNL_RX_LAST;
  logic [31:0]  CHNL_RX_LEN;
  logic [30:0]  CHNL_RX_OFF;
  logic [127:0] CHNL_RX_DATA;
  logic         CHNL_RX_DATA_VALID;
  logic         CHNL_RX_DATA_REN;

  modport master (
    output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    input  CHNL_RX_ACK, CHNL_RX_DATA_REN
  );
  modport slave (
    input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    output CHNL_RX_ACK, CHNL_RX_DATA_REN
  );
endinterface

interface axis_if;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/tx_axi_riffa.sv
// Host-to-card RIFFA RX bridge: validates the 128-bit metadata header of each framed
// transaction and replays its payload on an AXI4-Stream master with tuser/tkeep/tlast.
module tx_axi_riffa #(
  parameter int          C_PCI_DATA_WIDTH = 128,
  parameter logic [15:0] C_PREAM_VALUE    = 16'hCAFE,
  parameter int          C_MAX_PKT_SIZE   = 2000
) (
  input  logic        CLK,
  input  logic        RSTN,
  riffa_rx_if.slave   rx,
  axis_if.master      axis,
  output logic [31:0] drop_count
);
  localparam int DW     = C_PCI_DATA_WIDTH;
  localparam int KW     = DW / 8;
  localparam int DFW    = 1 + KW + DW;
  localparam int DDEPTH = 2 ** $clog2((C_MAX_PKT_SIZE + KW - 1) / KW + 2);
  localparam int DAW    = $clog2(DDEPTH);
  localparam int MDEPTH = 16;
  localparam int MAW    = 4;
  localparam logic [DAW:0] D_NFULL = DDEPTH - 1;
  localparam logic [MAW:0] M_NFULL = MDEPTH - 1;

  typedef enum logic [2:0] {IDLE, ACK, HDR, DATA, DRAIN} state_t;
  state_t state, state_next;

  logic [30:0]  rem, rem_dec, words;
  logic [31:0]  len_q;
  logic         drop_q;
  logic [11:0]  beat_cnt, beats;
  logic [15:0]  last_keep, keep_calc, pkt_len, preamble;
  logic [14:0]  dw_needed;
  logic         ren, accept, meta_push, data_push, drop_inc, hdr_ok, beat_last;
  logic         unused_inputs;

  logic [DFW-1:0] dmem [DDEPTH];
  logic [DAW-1:0] dwr, drd;
  logic [DAW:0]   dcount;
  logic [DFW-1:0] dhead;
  logic           dnfull, dpop;

  logic [127:0]   mmem [MDEPTH];
  logic [MAW-1:0] mwr, mrd;
  logic [MAW:0]   mcount;
  logic           mnfull, mpop;

  assign unused_inputs = ^{rx.CHNL_RX_LAST, rx.CHNL_RX_OFF};

  assign pkt_len   = rx.CHNL_RX_DATA[15:0];
  assign preamble  = rx.CHNL_RX_DATA[47:32];
  assign words     = {1'b0, rx.CHNL_RX_LEN[31:2]} + 31'(|rx.CHNL_RX_LEN[1:0]);
  assign dw_needed = {1'b0, pkt_len[15:2]} + 15'(|pkt_len[1:0]);
  assign beats     = pkt_len[15:4] + 12'(|pkt_len[3:0]);
  assign keep_calc = (pkt_len[3:0] == 4'd0) ? 16'hFFFF : 16'((17'd1 << pkt_len[3:0]) - 17'd1);
  // The transaction must carry the header plus every payload dword the header promises.
  assign hdr_ok = (preamble == C_PREAM_VALUE) && (pkt_len != 16'd0) &&
                  (32'(pkt_len) <= 32'(C_MAX_PKT_SIZE)) &&
                  ({1'b0, len_q} >= 33'd4 + 33'(dw_needed));

  assign rem_dec   = rem - 31'd1;
  assign accept    = ren & rx.CHNL_RX_DATA_VALID;
  assign beat_last = (beat_cnt == 12'd1);
  assign dnfull    = (dcount >= D_NFULL);
  assign mnfull    = (mcount >= M_NFULL);

  assign rx.CHNL_RX_ACK      = (state == ACK);
  assign rx.CHNL_RX_DATA_REN = ren;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ren        = 1'b0;
    meta_push  = 1'b0;
    data_push  = 1'b0;
    drop_inc   = 1'b0;
    case (state)
      IDLE: if (rx.CHNL_RX) state_next = ACK;
      ACK: begin
        if (drop_q) begin
          drop_inc   = 1'b1;
          state_next = (rem != 31'd0) ? DRAIN : IDLE;
        end else begin
          state_next = HDR;
        end
      end
      HDR: begin
        ren = ~mnfull;
        if (rx.CHNL_RX_DATA_VALID && !mnfull) begin
          if (hdr_ok) begin
            meta_push  = 1'b1;
            state_next = DATA;
          end else begin
            drop_inc   = 1'b1;
            state_next = (rem_dec != 31'd0) ? DRAIN : IDLE;
          end
        end
      end
      DATA: begin
        ren = ~dnfull;
        if (rx.CHNL_RX_DATA_VALID && !dnfull) begin
          data_push = 1'b1;
          if (beat_last) state_next = (rem_dec != 31'd0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        ren = 1'b1;
        if (rx.CHNL_RX_DATA_VALID && rem_dec == 31'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rem        <= '0;
      len_q      <= '0;
      drop_q     <= 1'b0;
      beat_cnt   <= '0;
      last_keep  <= '0;
      drop_count <= '0;
    end else begin
      if (state == IDLE && rx.CHNL_RX) begin
        rem    <= words;
        len_q  <= rx.CHNL_RX_LEN;
        drop_q <= (rx.CHNL_RX_LEN < 32'd4);
      end else if (accept) begin
        rem <= rem_dec;
      end
      if (meta_push) begin
        beat_cnt  <= beats;
        last_keep <= keep_calc;
      end else if (data_push) begin
        beat_cnt <= beat_cnt - 12'd1;
      end
      if (drop_inc && drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      dwr <= '0; drd <= '0; dcount <= '0;
      mwr <= '0; mrd <= '0; mcount <= '0;
    end else begin
      if (data_push) dwr <= dwr + 1'b1;
      if (dpop)      drd <= drd + 1'b1;
      dcount <= dcount + {{DAW{1'b0}}, data_push} - {{DAW{1'b0}}, dpop};
      if (meta_push) mwr <= mwr + 1'b1;
      if (mpop)      mrd <= mrd + 1'b1;
      mcount <= mcount + {{MAW{1'b0}}, meta_push} - {{MAW{1'b0}}, mpop};
    end
  end

  always_ff @(posedge CLK) begin
    if (data_push) dmem[dwr] <= {beat_last, beat_last ? last_keep : 16'hFFFF, rx.CHNL_RX_DATA};
    if (meta_push) mmem[mwr] <= {rx.CHNL_RX_DATA[127:64], 32'h0, rx.CHNL_RX_DATA[31:0]};
  end

  // Storage is not reset, so outputs are gated by tvalid to read zero when nothing is queued.
  assign dhead       = dmem[drd];
  assign axis.tvalid = (dcount != '0) && (mcount != '0);
  assign axis.tdata  = axis.tvalid ? dhead[DW-1:0] : '0;
  assign axis.tkeep  = axis.tvalid ? dhead[DW +: KW] : '0;
  assign axis.tlast  = axis.tvalid & dhead[DFW-1];
  assign axis.tuser  = axis.tvalid ? mmem[mrd] : '0;
  assign dpop        = axis.tvalid & axis.tready;
  assign mpop        = dpop & dhead[DFW-1];
endmodule

// File: doc/tx_axi_riffa.md
Name: tx_axi_riffa

Overview:
Host-to-card counterpart of the card-to-host RIFFA bridge. The block terminates one RIFFA RX channel, where the host writes framed packets. Each framed packet is one 128-bit metadata header word followed by payload. The block validates the header, turns it into AXI4-Stream tuser, and emits the payload on an AXIS master with correct tkeep and tlast toward the OSNT generator datapath.

Parameters:
C_PCI_DATA_WIDTH, 128, RIFFA/AXIS data width; only 128 supported.
C_PREAM_VALUE, 16'hCAFE, required header preamble.
C_MAX_PKT_SIZE, 2000, largest accepted packet in bytes; also sizes the data FIFO.

Ports:
CLK  in  1  core clock; all logic synchronous to it.
RSTN  in  1  asynchronous, active-low reset.
CHNL_RX  in  1  host transaction pending.
CHNL_RX_ACK  out  1  transaction accept pulse.
CHNL_RX_LAST  in  1  ignored.
CHNL_RX_LEN  in  32  transaction length in 32-bit dwords.
CHNL_RX_OFF  in  31  ignored.
CHNL_RX_DATA  in  128  data word.
CHNL_RX_DATA_VALID  in  1  data word valid.
CHNL_RX_DATA_REN  out  1  data word accepted when high together with VALID.
tdata  out  128  AXIS payload.
tkeep  out  16  byte enables.
tuser  out  128  metadata, held constant for the whole packet.
tvalid  out  1  AXIS valid.
tlast  out  1  last beat.
tready  in  1  AXIS ready.
drop_count  out  32  rejected transactions; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset: RSTN low asynchronously clears all state, counters and FIFOs. While in reset: CHNL_RX_ACK=0, CHNL_RX_DATA_REN=0, tvalid=0, tlast=0, tkeep=0, tdata=0, tuser=0, drop_count=0.
- Reset mid-transaction discards any partial packet; no AXIS beat of it may appear after reset.
- Header word layout:
  - [15:0] pkt_len, in bytes.
  - [23:16] src_port.
  - [31:24] dst_port.
  - [47:32] preamble.
  - [63:48] reserved.
  - [127:64] timestamp/user.
- tuser = {hdr[127:64], 32'h0, hdr[31:0]}.
- Definitions:
  - words = ceil(LEN/4).
  - beats = ceil(pkt_len/16).
  - Last-beat tkeep = low (pkt_len mod 16) bytes set, or 16'hFFFF when the remainder is 0.
  - All other beats: tkeep=16'hFFFF.
- Receive FSM states: IDLE, ACK, HDR, DATA, DRAIN.
- IDLE:
  - On CHNL_RX=1, latch words into remaining counter rem and go to ACK.
  - If LEN<4, latch rem=words and set the drop flag.
- ACK: CHNL_RX_ACK=1 for exactly one cycle.
  - Next state is DRAIN if the drop flag is set and rem>0.
  - Next state is IDLE if the drop flag is set and rem=0; increment drop_count on that exit.
  - Otherwise next state is HDR.
- HDR: REN = ~meta_nearly_full. On accept, decrement rem. The header is valid only if all of:
  - preamble == C_PREAM_VALUE;
  - 1 <= pkt_len <= C_MAX_PKT_SIZE;
  - LEN >= 4 + ceil(pkt_len/4).
- Valid header: push tuser to the metadata FIFO (depth 16), load the beat counter with beats, go to DATA.
- Invalid header: increment drop_count, go to DRAIN, or to IDLE if rem=0.
- DATA:
  - REN = ~data_nearly_full.
  - Each accepted word is pushed to the data FIFO as {last, keep, data}; decrement rem and the beat counter.
  - last=1 on the final beat.
  - After the final beat, go to DRAIN if rem>0, else IDLE.
- DRAIN: REN=1; discard words until rem=0, then go to IDLE. Padding and dropped transactions are consumed here.
- Completion is by word count only; CHNL_RX deassertion mid-transaction is ignored.
- AXIS output:
  - tvalid = data FIFO non-empty AND metadata FIFO non-empty.
  - tdata/tkeep/tlast come from the data FIFO head; tuser comes from the metadata FIFO head.
  - Pop the data FIFO on tvalid&tready; pop the metadata FIFO on tvalid&tready&tlast.
  - Outputs hold stable while tvalid&~tready.
- Zero-bubble: with tready=1 and CHNL_RX_DATA_VALID=1 continuous, sustain 1 beat/cycle. First-beat latency is at most 3 cycles from payload word accept.
- Simultaneous push/pop on the FIFOs is legal.
- The data FIFO holds at least one full C_MAX_PKT_SIZE packet.
- A new transaction may be acknowledged while earlier packets are still draining to AXIS.

Test Plan:
- 60-byte packet, LEN=19 (5 words), good preamble -> ACK pulse, 4 AXIS beats, tkeep FFFF,FFFF,FFFF,0FFF, tlast on beat 4, tuser[15:0]=16'd60, drop_count=0.
- 64-byte packet, LEN=24 (6 words) -> 4 beats all tkeep FFFF; 6th word drained and never emitted; next transaction ACKed.
- Preamble 16'hBEEF, LEN=8 -> all 2 words consumed, no AXIS output, drop_count=1. LEN=2 -> ACK, 1 word drained, drop_count=2.
- 1514-byte packet with tready low 200 cycles -> REN deasserts when the FIFO is nearly full; no data loss; 95 beats, last tkeep=16'h03FF.
- Back-to-back packets of 60 and 1500 bytes with tready=1 -> correct per-packet tuser; tlast boundaries exact; no idle beats within a packet.
- RSTN low mid-payload, then a fresh 60-byte packet -> all outputs 0 during reset; only the fresh packet appears on AXIS.
